// File: rtl/fft_stage_transpose_buffer_if.sv
// rtl/fft_stage_transpose_buffer_if.sv - row/column stream bundle for the FFT corner-turn buffer
//
// Groups the row input stream and the column output stream of the transpose buffer.
//   in_valid/in_ready : row handshake, set_in[k] = lane k of the row
//   out_valid         : set_out holds a valid column
//   frame_start       : high with column 0 of each output frame
//   set_out[k]        : lane k of the current output column
// Modports: slave = buffer side, master = producer/consumer side.
interface fft_stage_transpose_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0][DATA_WIDTH-1:0]  set_in;
  logic                        out_valid;
  logic                        frame_start;
  logic [7:0][DATA_WIDTH-1:0]  set_out;

  modport slave (
    input  in_valid,
    input  set_in,
    output in_ready,
    output out_valid,
    output frame_start,
    output set_out
  );

  modport master (
    output in_valid,
    output set_in,
    input  in_ready,
    input  out_valid,
    input  frame_start,
    input  set_out
  );
endinterface

// File: rtl/fft_stage_transpose_buffer.sv
// rtl/fft_stage_transpose_buffer.sv - ping-pong 8x8 corner-turn buffer between radix-8 FFT stages
//
// One bank fills row by row while the other drains column by column.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, released synchronously
//   hold : stage-wide stall, freezes every register and forces in_ready low
//   bus  : row input / column output streams (slave modport)
module fft_stage_transpose_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  fft_stage_transpose_buffer_if.slave   bus
);

  // Bank storage carries no reset; the full flags alone decide what is valid.
  logic [DATA_WIDTH-1:0]       mem_q [2][8][8];

  logic                        wr_bank_q, wr_bank_d;
  logic [2:0]                  wr_row_q, wr_row_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [2:0]                  rd_col_q, rd_col_d;
  logic [1:0]                  full_q, full_d;
  logic                        out_valid_q, out_valid_d;
  logic                        frame_start_q, frame_start_d;
  logic [7:0][DATA_WIDTH-1:0]  set_out_q, set_out_d;

  logic                        in_ready;
  logic                        wr_en;
  logic                        rd_en;

  assign in_ready = !hold && !full_q[wr_bank_q];
  assign wr_en    = bus.in_valid && in_ready;
  assign rd_en    = !hold && full_q[rd_bank_q];

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.set_out     = set_out_q;

  always_comb begin
    wr_bank_d     = wr_bank_q;
    wr_row_d      = wr_row_q;
    rd_bank_d     = rd_bank_q;
    rd_col_d      = rd_col_q;
    full_d        = full_q;
    out_valid_d   = out_valid_q;
    frame_start_d = frame_start_q;
    set_out_d     = set_out_q;

    // Row and column counters wrap naturally at 3 bits.
    if (wr_en) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Set and clear always target different banks when they coincide, so
    // applying them in sequence to full_d is order-independent.
    if (rd_en) begin
      rd_col_d      = rd_col_q + 3'd1;
      out_valid_d   = 1'b1;
      frame_start_d = (rd_col_q == 3'd0);
      for (int k = 0; k < 8; k++) begin
        set_out_d[k] = mem_q[rd_bank_q][k][rd_col_q];
      end
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (!hold) begin
      // Data lanes keep their last value while idle.
      out_valid_d   = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q     <= 1'b0;
      wr_row_q      <= 3'd0;
      rd_bank_q     <= 1'b0;
      rd_col_q      <= 3'd0;
      full_q        <= 2'b00;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      set_out_q     <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_row_q      <= wr_row_d;
      rd_bank_q     <= rd_bank_d;
      rd_col_q      <= rd_col_d;
      full_q        <= full_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      set_out_q     <= set_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[wr_bank_q][wr_row_q][k] <= bus.set_in[k];
      end
    end
  end

endmodule
